sprite_line_scanner: RTL and testbench
======================================

// Module: sprite_line_scanner
// PURPOSE
//  Per-scanline sprite evaluator, directly downstream of sprite_ram (32 x 40-bit attributes).
//  On each line start it walks sprite indexes 0..31 through the sprite_ram read port.
//  It decodes each attribute word and tests Y coverage of the current line.
//  Hits go into a small FIFO that the sprite line renderer drains with a valid/ready handshake.
// PARAMETERS
//  MAX_HITS    16  max sprites accepted per line (1..32); further hits set overflow_o
//  FIFO_DEPTH   4  output FIFO entries (power of 2, >=2)
// PORTS
//  clk_i          in   1   clock; also drives sprite_ram rd_clk_i
//  rst_i          in   1   synchronous reset, active-high
//  line_start_i   in   1   1-cycle pulse: begin scan for line_idx_i (sampled that cycle)
//  line_idx_i     in  10   current display line
//  sprites_en_i   in   1   0: scan completes with no hits
//  rd_addr_o      out  5   to sprite_ram rd_addr_i
//  rd_en_o        out  1   to sprite_ram rd_en_i / rd_clk_en_i
//  rd_data_i      in  40   from sprite_ram rd_data_o (registered, 1-cycle latency)
//  out_valid_o    out  1   FIFO head valid
//  out_ready_i    in   1   consumer accepts head when valid&ready
//  out_data_o     out 37   {width[36:35],bpp8[34],hflip[33],gfx[32:21],row[20:15],x[14:5],idx[4:0]}
//  busy_o         out  1   scan in progress
//  done_o         out  1   1-cycle pulse when scan of all 32 (or MAX_HITS) finishes
//  overflow_o     out  1   sticky per line: a hit was dropped because MAX_HITS was reached
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, FIFO empty, idx=0, hit_cnt=0.
//  Attribute word: [11:0] gfx addr, [12] vflip, [13] hflip, [14] bpp8, [15] enable,
//   [25:16] x, [35:26] y, [37:36] height code, [39:38] width code; code 0..3 = 8/16/32/64 px.
//  FSM: IDLE -> ISSUE -> EVAL -> (ISSUE | DONE) -> IDLE.
//   IDLE: on line_start_i latch line_idx_i, clear hit_cnt/overflow_o, idx=0, go ISSUE.
//   ISSUE: rd_addr_o=idx, rd_en_o=1; RAM samples at end of cycle.
//   EVAL: rd_data_i valid; rd_addr_o held so data stays stable across stalls.
//   DONE: done_o=1 for one cycle, busy_o=0 next cycle, go IDLE.
//  Cost: 2 cycles/sprite; 32 sprites, no stalls -> done_o 65 cycles after line_start_i.
//  Hit test in EVAL: row = (line - y) mod 1024 (10-bit wrap); hit = enable & sprites_en_i & row < 8<<hcode.
//   Y wrap: y=1020, h=8 hits lines 1020..1023 and 0..3.
//  Out row = vflip ? (8<<hcode)-1-row : row, truncated to 6 bits.
//  Hit with hit_cnt<MAX_HITS and FIFO not full: push, hit_cnt++, advance.
//   Hit with FIFO full: stay in EVAL (stall) until a pop frees space.
//   Hit with hit_cnt==MAX_HITS: set overflow_o, go DONE (stop scanning).
//   No hit: advance. Advance: idx==31 -> DONE, else idx++ -> ISSUE.
//  Push and pop in the same cycle are legal with the FIFO full; count unchanged.
//  FIFO is first-word-fall-through; out_data_o is stable while out_valid_o & !out_ready_i.
//  Lower idx is always emitted first (priority order).
//  line_start_i while busy_o: abort, flush FIFO, restart from idx 0 next cycle.
//   No done_o is issued for the aborted line.
//  line_start_i in DONE: accepted, same as IDLE.
//  FIFO is not flushed at DONE; the consumer drains it after done_o.
//  overflow_o holds until the next line_start_i.
// CONFIGURATION
//  SPRITE_SCAN_STATS_EN defined: extra port hit_count_o out 6.
//   Latched from hit_cnt in the DONE cycle, held until next DONE; reset 0.
//  Not defined: port absent, no counter register beyond hit_cnt; behaviour otherwise identical.
// TESTING
//  Sprite1 enable,x=123,y=0,h=8; line 3; ready=1 -> one pop idx=1,x=123,row=3; done_o at cycle 65.
//  Same plus vflip, h=16, line 5 -> row=10; line 16 -> no hit, done_o with FIFO empty.
//  y=1020,h=8: lines 1023 and 2 -> hits, row 3 and 6; line 4 -> no hit.
//  All 32 enabled covering line 0, MAX_HITS=16, ready=0 -> stall at 4 entries.
//   Then ready=1 -> idx 0..15 in order, overflow_o=1, done_o after 16th push.
//  line_start_i at cycle 20 of a scan -> FIFO flushed, no done_o, rescan completes 65 cycles later.
//  Reset asserted mid-stall -> all outputs 0 next cycle; sprites_en_i=0 -> done_o with zero hits.

Source files
------------

// File: rtl/sprite_line_scanner.sv
// sprite_line_scanner: per-scanline sprite evaluator feeding a FWFT hit FIFO.
// Walks sprite_ram indexes 0..31 at each line start (issue/eval, 2 cycles per sprite),
// tests Y coverage of the latched line and queues hits for the line renderer.
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   line_start_i, line_idx_i  start (or abort and restart) a scan of line_idx_i
//   sprites_en_i              0: scan runs but never hits
//   rd_addr_o, rd_en_o        sprite_ram read port (1-cycle registered data)
//   rd_data_i                 40-bit attribute word from sprite_ram
//   out_valid_o/out_ready_i   FIFO head handshake, out_data_o is the head entry
//   busy_o, done_o            scan in progress, 1-cycle end-of-scan pulse
//   overflow_o                sticky per line: a hit was dropped at MAX_HITS
//   hit_count_o               only with SPRITE_SCAN_STATS_EN: hits of the last finished line
module sprite_line_scanner #(
    parameter int MAX_HITS   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        line_start_i,
    input  logic [9:0]  line_idx_i,
    input  logic        sprites_en_i,
    output logic [4:0]  rd_addr_o,
    output logic        rd_en_o,
    input  logic [39:0] rd_data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [36:0] out_data_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        overflow_o
`ifdef SPRITE_SCAN_STATS_EN
    ,
    output logic [5:0]  hit_count_o
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, ISSUE, EVAL, DONE} state_t;
    state_t      state_q, state_d;
    logic [9:0]  line_q, line_d;
    logic [4:0]  idx_q, idx_d;
    logic [5:0]  hit_cnt_q, hit_cnt_d;
    logic        ovf_q, ovf_d;
    logic [36:0] mem_q [FIFO_DEPTH];
    logic [36:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0] cnt_q, cnt_d;
    logic [9:0]  row_full;
    logic [6:0]  height;
    logic [5:0]  out_row;
    logic [36:0] push_data;
    logic        hit, full, pop, push, flush;

    // Row wraps modulo 1024 so sprites straddling the bottom edge reappear at the top.
    assign row_full  = line_q - rd_data_i[35:26];
    assign height    = 7'd8 << rd_data_i[37:36];
    assign hit       = rd_data_i[15] & sprites_en_i & (row_full < 10'(height));
    assign out_row   = rd_data_i[12] ? 6'(height - 7'd1 - row_full[6:0]) : row_full[5:0];
    assign push_data = {rd_data_i[39:38], rd_data_i[14], rd_data_i[13], rd_data_i[11:0],
                        out_row, rd_data_i[25:16], idx_q};
    assign full      = cnt_q == (AW+1)'(FIFO_DEPTH);
    assign pop       = out_valid_o & out_ready_i;

    assign rd_addr_o   = idx_q;
    assign rd_en_o     = state_q == ISSUE;
    assign out_valid_o = cnt_q != '0;
    assign out_data_o  = mem_q[rd_q];
    assign busy_o      = state_q != IDLE;
    assign done_o      = state_q == DONE;
    assign overflow_o  = ovf_q;

    always_comb begin
        state_d   = state_q;
        line_d    = line_q;
        idx_d     = idx_q;
        hit_cnt_d = hit_cnt_q;
        ovf_d     = ovf_q;
        push      = 1'b0;
        flush     = 1'b0;
        case (state_q)
            ISSUE: state_d = EVAL;
            EVAL: begin
                if (hit && hit_cnt_q == 6'(MAX_HITS)) begin
                    ovf_d   = 1'b1;
                    state_d = DONE;
                end else if (!hit || !full || pop) begin
                    // A full FIFO stalls here with rd_addr_o held, so rd_data_i stays valid.
                    push      = hit;
                    hit_cnt_d = hit_cnt_q + {5'd0, hit};
                    state_d   = idx_q == 5'd31 ? DONE : ISSUE;
                    idx_d     = idx_q == 5'd31 ? idx_q : idx_q + 5'd1;
                end
            end
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (line_start_i) begin
            flush     = state_q == ISSUE || state_q == EVAL;
            push      = 1'b0;
            state_d   = ISSUE;
            line_d    = line_idx_i;
            idx_d     = '0;
            hit_cnt_d = '0;
            ovf_d     = 1'b0;
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_q] = push_data;
        wr_d  = flush ? '0 : wr_q + AW'(push);
        rd_d  = flush ? '0 : rd_q + AW'(pop);
        cnt_d = flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            line_q    <= '0;
            idx_q     <= '0;
            hit_cnt_q <= '0;
            ovf_q     <= 1'b0;
            mem_q     <= '{default: '0};
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            line_q    <= line_d;
            idx_q     <= idx_d;
            hit_cnt_q <= hit_cnt_d;
            ovf_q     <= ovf_d;
            mem_q     <= mem_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
        end
    end

`ifdef SPRITE_SCAN_STATS_EN
    logic [5:0] hit_count_q, hit_count_d;
    assign hit_count_o = hit_count_q;
    always_comb hit_count_d = state_q == DONE ? hit_cnt_q : hit_count_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) hit_count_q <= '0;
        else       hit_count_q <= hit_count_d;
    end
`endif
endmodule

// File: tb/tb_sprite_line_scanner.sv
// tb_sprite_line_scanner: vector table, corner sequences and random lines vs a reference model.
module tb_sprite_line_scanner;
    localparam int MAX_HITS = 16;
    logic        clk = 1'b0;
    logic        rst, line_start, sen, out_ready, rd_en, out_valid, busy, done, ovf;
    logic [9:0]  line_idx;
    logic [4:0]  rd_addr;
    logic [39:0] rd_data;
    logic [36:0] out_data;
    logic [39:0] ram [32];
    int errors = 0, checks = 0;
    logic [36:0] exp_q[$];
    logic [36:0] got_q[$];
    bit exp_ovf, got_ovf;
    int exp_lat, done_cnt, done_cyc;

    typedef struct {
        logic [39:0] attr;
        int          line;
        bit          s;
        bit          hit;
        int          row;
    } vec_t;
    vec_t tbl[9];

    always #5 clk = ~clk;
    always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

    sprite_line_scanner #(.MAX_HITS(MAX_HITS), .FIFO_DEPTH(4)) dut (
        .clk_i(clk), .rst_i(rst), .line_start_i(line_start), .line_idx_i(line_idx),
        .sprites_en_i(sen), .rd_addr_o(rd_addr), .rd_en_o(rd_en), .rd_data_i(rd_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .busy_o(busy), .done_o(done), .overflow_o(ovf)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] mk(int gfx, bit vf, bit hf, bit b8, bit en,
                                       int x, int y, int hc, int wc);
        return {2'(wc), 2'(hc), 10'(y), 10'(x), en, b8, hf, vf, 12'(gfx)};
    endfunction

    task automatic clear_ram();
        for (int i = 0; i < 32; i++) ram[i] = '0;
    endtask

    // Reference: list the hits of a line straight from the attribute rules.
    task automatic model(input int line, input bit s);
        logic [39:0] a;
        int y, h, row, r;
        exp_q.delete();
        exp_ovf = 0;
        exp_lat = 65;
        for (int i = 0; i < 32; i++) begin
            a   = ram[i];
            y   = int'(a[35:26]);
            h   = 8 << a[37:36];
            row = (line + 1024 - y) % 1024;
            if (!(a[15] && s && row < h)) continue;
            if (exp_q.size() == MAX_HITS) begin
                exp_ovf = 1;
                exp_lat = 2 * i + 3;
                break;
            end
            r = a[12] ? h - 1 - row : row;
            exp_q.push_back({a[39:38], a[14], a[13], a[11:0], 6'(r), a[25:16], 5'(i)});
        end
    endtask

    // mode 0: ready=1, mode 1: random ready, mode 2: ready=0 until cycle 40.
    task automatic scan(input int line, input bit s, input int mode, input int abort_at);
        int cyc;
        bit fin, aborted, just_ab;
        got_q.delete();
        done_cnt = 0;
        done_cyc = 0;
        got_ovf  = 0;
        @(negedge clk);
        line_idx   = 10'(line);
        sen        = s;
        line_start = 1'b1;
        out_ready  = mode == 0;
        cyc        = 0;
        fin        = 0;
        aborted    = abort_at == 0;
        just_ab    = 0;
        while (!fin) begin
            @(negedge clk);
            line_start = 1'b0;
            cyc++;
            if (just_ab) begin
                chk("abort_flush", out_valid, 0);
                chk("abort_no_done", done_cnt, 0);
                cyc     = 1;
                just_ab = 0;
                got_q.delete();
            end
            if (mode == 2 && abort_at == 0 && cyc == 40) begin
                chk("stall_addr", rd_addr, 4);
                chk("stall_valid", out_valid, 1);
                chk("stall_head_idx", out_data[4:0], 0);
                chk("stall_no_pops", got_q.size(), 0);
                chk("stall_no_done", done_cnt, 0);
            end
            out_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom % 2) : cyc >= 40;
            if (out_valid && out_ready) got_q.push_back(out_data);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                got_ovf  = ovf;
            end
            if (!aborted && cyc == abort_at) begin
                chk("abort_prefill", out_valid, 1);
                line_start = 1'b1;
                aborted    = 1;
                just_ab    = 1;
            end else if (done_cnt > 0 && !out_valid) fin = 1;
            if (cyc > 3000) begin
                chk("scan_timeout", cyc, 0);
                fin = 1;
            end
        end
        @(negedge clk);
        chk("idle_after_done", {busy, done}, 0);
        model(line, s);
        chk("hit_count", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk($sformatf("hit_data[%0d]", i), got_q[i], exp_q[i]);
        chk("overflow", got_ovf, exp_ovf);
        chk("done_pulses", done_cnt, 1);
        if (mode == 0 || abort_at != 0) chk("done_latency", done_cyc, exp_lat);
    endtask

    initial begin
        tbl[0] = '{mk(12'h0AB, 0, 0, 0, 1, 123, 0, 0, 0), 3, 1, 1, 3};
        tbl[1] = '{mk(12'h0AB, 1, 0, 0, 1, 123, 0, 1, 0), 5, 1, 1, 10};
        tbl[2] = '{mk(12'h0AB, 1, 0, 0, 1, 123, 0, 1, 0), 16, 1, 0, 0};
        tbl[3] = '{mk(12'h123, 0, 0, 0, 1, 7, 1020, 0, 1), 1023, 1, 1, 3};
        tbl[4] = '{mk(12'h123, 0, 0, 0, 1, 7, 1020, 0, 1), 2, 1, 1, 6};
        tbl[5] = '{mk(12'h123, 0, 0, 0, 1, 7, 1020, 0, 1), 4, 1, 0, 0};
        tbl[6] = '{mk(12'h0AB, 0, 0, 0, 1, 123, 0, 0, 0), 3, 0, 0, 0};
        tbl[7] = '{mk(12'h0AB, 0, 0, 0, 0, 123, 0, 0, 0), 3, 1, 0, 0};
        tbl[8] = '{mk(12'hFFF, 1, 1, 1, 1, 1023, 100, 3, 2), 163, 1, 1, 0};
        clear_ram();
        rst = 1'b1; line_start = 1'b0; sen = 1'b0; out_ready = 1'b0; line_idx = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {busy, done, ovf, out_valid, rd_en, rd_addr, out_data}, 0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            clear_ram();
            ram[1] = tbl[i].attr;
            scan(tbl[i].line, tbl[i].s, 0, 0);
            chk($sformatf("vec%0d_hit", i), got_q.size(), tbl[i].hit);
            if (tbl[i].hit && got_q.size() > 0) begin
                chk($sformatf("vec%0d_row", i), got_q[0][20:15], tbl[i].row);
                chk($sformatf("vec%0d_idx", i), got_q[0][4:0], 1);
            end
        end

        for (int i = 0; i < 32; i++) ram[i] = mk(i, 0, 0, 0, 1, 4 * i, 0, 0, 0);
        scan(0, 1, 2, 0);
        chk("maxhits_pops", got_q.size(), 16);
        chk("maxhits_last_idx", got_q.size() == 16 ? got_q[15][4:0] : 5'h1F, 15);
        chk("maxhits_ovf", got_ovf, 1);

        clear_ram();
        ram[1] = mk(1, 0, 0, 0, 1, 10, 0, 0, 0);
        ram[3] = mk(3, 0, 0, 0, 1, 30, 0, 0, 0);
        scan(3, 1, 2, 19);
        chk("abort_rescan_pops", got_q.size(), 2);

        for (int i = 0; i < 32; i++) ram[i] = mk(i, 0, 0, 0, 1, i, 0, 0, 0);
        @(negedge clk);
        line_idx = '0; sen = 1'b1; line_start = 1'b1; out_ready = 1'b0;
        repeat (30) begin
            @(negedge clk);
            line_start = 1'b0;
        end
        chk("pre_rst_stalled", {busy, out_valid}, 2'b11);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_stall", {busy, done, ovf, out_valid, rd_en, rd_addr, out_data}, 0);

        for (int n = 0; n < 25; n++) begin
            int line;
            logic [39:0] a;
            line = int'($urandom_range(0, 1023));
            for (int i = 0; i < 32; i++) begin
                a          = {$urandom, $urandom} & 40'hFF_FFFF_FFFF;
                a[35:26]   = 10'(line - int'($urandom_range(0, 70)));
                a[15]      = ($urandom % 4) != 0;
                ram[i]     = a;
            end
            scan(line, ($urandom % 8) != 0, 1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
